inst_mem: RTL

Word-organised instruction memory that answers the CPU core's instruction fetch port (`rom_ce`/`rom_addr` in, `rom_data` out), plus a byte-serial program loader that fills the memory at run time. It sits beside the core at top level. While a program loads, it holds the core in reset through a dedicated reset output, then releases it when loading completes.

---
 rtl/inst_mem_if.sv | 56 +++++
 rtl/inst_mem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inst_mem_if.sv
// ----------------------------------------------------------------------------
// inst_mem_if
// Bundles the instruction fetch port and the byte-serial program loader port
// of inst_mem.
//
// Parameters:
//   InstMemNumLog2 - log2 of the memory depth in words. It sets the width of
//                    load_words_o.
//
// Signals:
//   rom_ce_i, rom_addr_i[31:0]   fetch enable and byte address from the core
//   rom_data_o[31:0]             fetched instruction
//   load_start_i                 begin or restart a program load
//   load_valid_i, load_byte_i    program byte stream, big-endian
//   load_last_i                  marks the final byte of the image
//   load_ready_o                 loader accepts a byte this cycle
//   load_done_o, load_err_o      load finished / image exceeded capacity
//   load_words_o                 number of words written by the current load
//   cpu_rst_o                    reset to the core
//
// Modports:
//   master - core and loader side (drives fetch and load requests)
//   slave  - memory side (inst_mem)
// ----------------------------------------------------------------------------
interface inst_mem_if #(
   parameter int InstMemNumLog2 = 10
);
   logic                      rom_ce_i;
   logic [31:0]               rom_addr_i;
   logic [31:0]               rom_data_o;
   logic                      load_start_i;
   logic                      load_valid_i;
   logic [7:0]                load_byte_i;
   logic                      load_last_i;
   logic                      load_ready_o;
   logic                      load_done_o;
   logic                      load_err_o;
   logic [InstMemNumLog2:0]   load_words_o;
   logic                      cpu_rst_o;

   // The core and the program source drive requests and observe status.
   modport master (
      output rom_ce_i, rom_addr_i,
      output load_start_i, load_valid_i, load_byte_i, load_last_i,
      input  rom_data_o, load_ready_o, load_done_o, load_err_o,
      input  load_words_o, cpu_rst_o
   );

   // The memory answers fetches and runs the loader.
   modport slave (
      input  rom_ce_i, rom_addr_i,
      input  load_start_i, load_valid_i, load_byte_i, load_last_i,
      output rom_data_o, load_ready_o, load_done_o, load_err_o,
      output load_words_o, cpu_rst_o
   );
endinterface

// File: rtl/inst_mem.sv
// ----------------------------------------------------------------------------
// inst_mem
// Word-organised instruction memory with a zero-latency fetch port for the
// core and a byte-serial program loader that fills it at run time. The core
// is held in reset through cpu_rst_o for as long as a load is in progress.
//
// Parameters:
//   InstMemNum     - depth in 32-bit words, power of two
//   InstMemNumLog2 - log2(InstMemNum)
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - inst_mem_if.slave: fetch port, loader stream, status, cpu_rst_o
//
// Configuration macro:
//   INST_MEM_ADDR_CHECK_EN - when defined, a fetch with any address bit above
//                            InstMemNumLog2+1 set returns 0x00000000; when
//                            undefined, those bits are ignored and the address
//                            wraps modulo InstMemNum words.
// ----------------------------------------------------------------------------
module inst_mem #(
   parameter int InstMemNum     = 1024,
   parameter int InstMemNumLog2 = 10
) (
   input logic        clk,
   input logic        rst,
   inst_mem_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } load_state_t;

   // Write pointer value at which the memory is full.
   localparam logic [InstMemNumLog2:0] FullCount = InstMemNum[InstMemNumLog2:0];

   logic [31:0]               mem [InstMemNum];

   load_state_t               state;
   logic [InstMemNumLog2:0]   wptr;
   logic [1:0]                byte_cnt;
   logic [31:0]               word_buf;
   logic                      done_q;
   logic                      err_q;

   logic                      ready;
   logic                      accept;
   logic                      full;
   logic                      word_we;
   logic [31:0]               word_next;
   logic [InstMemNumLog2-1:0] fetch_idx;
   logic                      addr_ok;

   // A byte is only taken while loading and out of reset. A start pulse in
   // the same cycle restarts the load, so that byte is dropped.
   assign ready  = (state == LOAD) && !rst;
   assign accept = ready && bus.load_valid_i && !bus.load_start_i;
   assign full   = (wptr == FullCount);

   // Merge the incoming byte into the word being assembled. The buffer holds
   // zeros in the lanes not yet filled, so a word closed early by load_last_i
   // comes out zero-padded in its low bytes.
   always_comb begin
      word_next = word_buf;
      case (byte_cnt)
         2'd0:    word_next[31:24] = bus.load_byte_i;
         2'd1:    word_next[23:16] = bus.load_byte_i;
         2'd2:    word_next[15:8]  = bus.load_byte_i;
         default: word_next[7:0]   = bus.load_byte_i;
      endcase
   end

   // A word is committed on its 4th byte, or earlier when the last byte of
   // the image arrives. Bytes arriving once the memory is full never write.
   assign word_we = accept && !full && ((byte_cnt == 2'd3) || bus.load_last_i);

   // Loader FSM. Restart from any state clears the pointer, the partial word
   // and the status flags. Overflow ends the load with both done and err set.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wptr     <= '0;
         byte_cnt <= 2'd0;
         word_buf <= 32'h0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (bus.load_start_i) begin
         state    <= LOAD;
         wptr     <= '0;
         byte_cnt <= 2'd0;
         word_buf <= 32'h0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (accept) begin
         if (full) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
         end else begin
            if (word_we) begin
               wptr     <= wptr + 1'b1;
               byte_cnt <= 2'd0;
               word_buf <= 32'h0;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               word_buf <= word_next;
            end
            if (bus.load_last_i) begin
               done_q <= 1'b1;
               state  <= DONE;
            end
         end
      end
   end

   // Memory array write port. Contents are deliberately not reset so that a
   // preloaded image survives a system reset.
   always_ff @(posedge clk) begin
      if (word_we) begin
         mem[wptr[InstMemNumLog2-1:0]] <= word_next;
      end
   end

   // Fetch address decode. Byte offset bits are ignored; the upper bits are
   // either range-checked or dropped so the address wraps.
   assign fetch_idx = bus.rom_addr_i[InstMemNumLog2+1:2];

`ifdef INST_MEM_ADDR_CHECK_EN
   assign addr_ok = ~|bus.rom_addr_i[31:InstMemNumLog2+2];
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, bus.rom_addr_i[1:0]};
`else
   assign addr_ok = 1'b1;
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, bus.rom_addr_i[31:InstMemNumLog2+2], bus.rom_addr_i[1:0]};
`endif

   // Asynchronous read: the core latches PC and instruction on the same edge.
   // A nop is returned while disabled, in reset, or while the image is being
   // rewritten.
   assign bus.rom_data_o = (bus.rom_ce_i && (state != LOAD) && !rst && addr_ok)
                           ? mem[fetch_idx] : 32'h0000_0000;

   // Status outputs. cpu_rst_o covers the loading window so the core's first
   // fetch after release sees the complete image.
   assign bus.load_ready_o = ready;
   assign bus.load_done_o  = done_q;
   assign bus.load_err_o   = err_q;
   assign bus.load_words_o = wptr;
   assign bus.cpu_rst_o    = rst || (state == LOAD);

endmodule
